// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int unsigned RF_XLEN   = 32;
  localparam int unsigned RF_NREGS  = 32;
  localparam int unsigned ZERO_ADDR = 0;

  function automatic int unsigned rf_aw(input int unsigned nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Decode/writeback-facing bus of the register file: read, write, issue and busy signals.
interface multiport_regfile_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN,
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
);
  localparam int unsigned AW = rf_aw(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on write.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NRD*rf_aw(NREGS)-1:0]     rd_addr,
  input  logic [NWR-1:0]                  wr_en,
  input  logic [NWR*rf_aw(NREGS)-1:0]     wr_addr,
  input  logic                            iss_valid,
  input  logic [rf_aw(NREGS)-1:0]         iss_addr,
  output logic [NRD-1:0]                  rd_busy,
  output logic                            any_busy
);
  localparam int unsigned AW = rf_aw(NREGS);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Issue is applied after the clears so a same-cycle issue leaves the register busy.
  always_comb begin
    busy_next = busy;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_next[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid) busy_next[iss_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      logic [AW-1:0] ra;
      logic          hit;
      ra  = rd_addr[k*AW +: AW];
      hit = 1'b0;
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == ra) hit = 1'b1;
      end
      rd_busy[k] = busy[ra] && !(BYPASS != 0 && hit) && !rst;
    end
  end

  assign any_busy = |busy;

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multi-port register file with write priority, read bypass and a busy scoreboard.
module multiport_regfile
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = RF_XLEN,
  parameter int unsigned NREGS    = RF_NREGS,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input logic               clk,
  input logic               rst,
  multiport_regfile_if.slave bus
);
  localparam int unsigned AW = rf_aw(NREGS);

  logic [XLEN-1:0]     mem [NREGS];
  logic [NWR-1:0]      wr_keep;
  logic [NRD*XLEN-1:0] rd_data_c;

  always_comb begin
    wr_keep = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      wr_keep[j] = bus.wr_en[j] &&
                   !(ZERO_REG != 0 && bus.wr_addr[j*AW +: AW] == AW'(ZERO_ADDR));
    end
  end

  // Ascending port order: the last non-blocking update to an address wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_keep[j]) mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rv;
      ra = bus.rd_addr[k*AW +: AW];
      rv = mem[ra];
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra) rv = bus.wr_data[j*XLEN +: XLEN];
        end
      end
      if (rst || (ZERO_REG != 0 && ra == AW'(ZERO_ADDR))) rv = '0;
      rd_data_c[k*XLEN +: XLEN] = rv;
    end
  end

  assign bus.rd_data = rd_data_c;

  rf_scoreboard #(
    .NREGS   (NREGS),
    .NRD     (NRD),
    .NWR     (NWR),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (bus.rd_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_valid(bus.iss_valid),
    .iss_addr (bus.iss_addr),
    .rd_busy  (bus.rd_busy),
    .any_busy (bus.any_busy)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed checks of two register-file configurations: 2-write bypassing and 1-write registered-read.
module tb_multiport_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  multiport_regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
  multiport_regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) ifb ();

  multiport_regfile #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  multiport_regfile #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.iss_valid = 1'b0; ifa.iss_addr = '0;
    ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.iss_valid = 1'b0; ifb.iss_addr = '0;
  endtask

  // Advance to just after the next rising edge, where new stimulus is applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    ifa.rd_addr = '0;
    ifb.rd_addr = '0;
    #2;
    check("reset_rd_data", ifa.rd_data[31:0], 32'h0);
    check("reset_any_busy", 32'(ifa.any_busy), 32'h0);
    tick();
    rst = 1'b0;

    // Reset: write x5, mark x6 pending, then assert reset mid-cycle.
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd5}; ifa.wr_data = {32'h0, 32'hDEADBEEF};
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd6;
    tick();
    idle();
    ifa.rd_addr = {5'd0, 5'd5};
    #1;
    check("x5_written", ifa.rd_data[31:0], 32'hDEADBEEF);
    check("x6_pending_any_busy", 32'(ifa.any_busy), 32'h1);
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd5}; ifa.wr_data = {32'h0, 32'h11111111};
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_rd_data", ifa.rd_data[31:0], 32'h0);
    check("rst_async_any_busy", 32'(ifa.any_busy), 32'h0);
    tick();
    idle();
    #1;
    rst = 1'b0;
    #1;
    check("x5_after_release", ifa.rd_data[31:0], 32'h0);
    tick();

    // Bypass vs registered read of x7.
    ifa.rd_addr = {5'd0, 5'd7}; ifb.rd_addr = {5'd0, 5'd7};
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd7}; ifa.wr_data = {32'h0, 32'h12345678};
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd7; ifb.wr_data = 32'h12345678;
    #1;
    check("bypass_same_cycle", ifa.rd_data[31:0], 32'h12345678);
    check("nobypass_old_value", ifb.rd_data[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("nobypass_next_cycle", ifb.rd_data[31:0], 32'h12345678);
    check("bypass_stored", ifa.rd_data[31:0], 32'h12345678);

    // Zero register: write and issue x0.
    ifa.rd_addr = {5'd0, 5'd0};
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd0}; ifa.wr_data = {32'h0, 32'hFFFFFFFF};
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd0;
    #1;
    check("x0_bypass_zero", ifa.rd_data[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("x0_reads_zero", ifa.rd_data[31:0], 32'h0);
    check("x0_not_busy", 32'(ifa.rd_busy[0]), 32'h0);
    check("x0_any_busy", 32'(ifa.any_busy), 32'h0);

    // Write conflict on x3: port 1 wins.
    ifa.rd_addr = {5'd3, 5'd0};
    ifa.wr_en = 2'b11; ifa.wr_addr = {5'd3, 5'd3}; ifa.wr_data = {32'h2, 32'h1};
    #1;
    check("conflict_bypass", ifa.rd_data[63:32], 32'h2);
    tick();
    idle();
    #1;
    check("conflict_stored", ifa.rd_data[63:32], 32'h2);

    // Scoreboard on x9 across both configurations.
    ifa.rd_addr = {5'd0, 5'd9}; ifb.rd_addr = {5'd0, 5'd9};
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd9;
    ifb.iss_valid = 1'b1; ifb.iss_addr = 5'd9;
    #1;
    check("sb_c0_not_yet_busy", 32'(ifa.rd_busy[0]), 32'h0);
    tick();
    idle();
    #1;
    check("sb_c1_busy", 32'(ifa.rd_busy[0]), 32'h1);
    check("sb_c1_any_busy", 32'(ifa.any_busy), 32'h1);
    check("sb_b_c1_busy", 32'(ifb.rd_busy[0]), 32'h1);
    tick();
    #1;
    check("sb_c2_busy", 32'(ifa.rd_busy[0]), 32'h1);
    tick();
    ifa.wr_en = 2'b10; ifa.wr_addr = {5'd9, 5'd0}; ifa.wr_data = {32'hA5, 32'h0};
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd9; ifb.wr_data = 32'hA5;
    #1;
    check("sb_c3_bypass_clear", 32'(ifa.rd_busy[0]), 32'h0);
    check("sb_c3_any_busy_held", 32'(ifa.any_busy), 32'h1);
    check("sb_b_c3_still_busy", 32'(ifb.rd_busy[0]), 32'h1);
    tick();
    idle();
    #1;
    check("sb_c4_any_busy", 32'(ifa.any_busy), 32'h0);
    check("sb_b_c4_cleared", 32'(ifb.rd_busy[0]), 32'h0);
    check("sb_c4_data", ifa.rd_data[31:0], 32'hA5);

    // Simultaneous issue and write of x4: data lands, busy stays set.
    ifa.rd_addr = {5'd0, 5'd4};
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd4}; ifa.wr_data = {32'h0, 32'hCAFE0004};
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd4;
    tick();
    idle();
    #1;
    check("iss_wr_x4_data", ifa.rd_data[31:0], 32'hCAFE0004);
    check("iss_wr_x4_busy", 32'(ifa.rd_busy[0]), 32'h1);
    check("iss_wr_x4_any_busy", 32'(ifa.any_busy), 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
